// File: rtl/load_store_unit.sv
// Data-memory initiator: byte-addressed loads/stores onto a 64-bit word-addressed memory port.
// Latency after accept: misaligned 1, load 2, SD 2, SB/SH/SW 3 (read-modify-write) cycles.
// Backpressure: req_ready is high only in IDLE, so one request is in flight at a time.
//
// Ports: clk/reset (sync, active-high); req_* request channel (valid/ready);
// resp_* one-cycle completion pulse with extended load data and misalignment flag;
// mem_* drive the data_memory port (mem_read_data is combinational while mem_read=1).
// Optional feature: define LSU_MISALIGN_CHECK_EN to report misaligned requests instead of
// aligning the address down.
module load_store_unit #(
  parameter int WORD_ADDR_W = 6
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_write,
  input  logic [1:0]               req_size,
  input  logic                     req_unsigned,
  input  logic [WORD_ADDR_W+2:0]   req_addr,
  input  logic [63:0]              req_wdata,
  output logic                     resp_valid,
  output logic [63:0]              resp_rdata,
  output logic                     resp_misaligned,
  output logic [WORD_ADDR_W-1:0]   mem_address,
  output logic [63:0]              mem_write_data,
  output logic                     mem_read,
  output logic                     mem_write,
  input  logic [63:0]              mem_read_data
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t                 state_q, state_d;
  logic                   write_q;
  logic [1:0]             size_q;
  logic                   uns_q;
  logic [WORD_ADDR_W-1:0] index_q;
  logic [2:0]             off_q;
  logic [63:0]            wdata_q;
  logic                   mis_q;
  logic [63:0]            data_q;   // extended load result, or merge base for a store

  logic       accept;
  logic [2:0] req_off;
  logic [2:0] align_off;
  logic       req_mis;

  assign accept  = req_valid && req_ready;
  assign req_off = req_addr[2:0];

  // Offset aligned down to the access granule. With checking enabled, any request that
  // would be changed by this is flagged and never reaches memory, so it is safe either way.
  always_comb begin
    align_off = req_off;
    case (req_size)
      2'b01:   align_off = {req_off[2:1], 1'b0};
      2'b10:   align_off = {req_off[2], 2'b00};
      2'b11:   align_off = 3'b000;
      default: align_off = req_off;
    endcase
  end

`ifdef LSU_MISALIGN_CHECK_EN
  assign req_mis = (align_off != req_off);
`else
  assign req_mis = 1'b0;
`endif

  // Load lane extraction and extension
  logic [63:0] lane;
  logic [63:0] load_ext;

  assign lane = mem_read_data >> {off_q, 3'b000};

  always_comb begin
    load_ext = lane;
    case (size_q)
      2'b00:   load_ext = uns_q ? {56'h0, lane[7:0]}  : {{56{lane[7]}},  lane[7:0]};
      2'b01:   load_ext = uns_q ? {48'h0, lane[15:0]} : {{48{lane[15]}}, lane[15:0]};
      2'b10:   load_ext = uns_q ? {32'h0, lane[31:0]} : {{32{lane[31]}}, lane[31:0]};
      default: load_ext = lane;   // doubleword: offset is always 0 here
    endcase
  end

  // Store merge: replace the addressed byte lanes of the read-back word with wdata
  logic [7:0]  be_base;
  logic [7:0]  byte_en;
  logic [63:0] bit_mask;
  logic [63:0] wdata_sh;
  logic [63:0] merged;

  always_comb begin
    be_base = 8'h01;
    case (size_q)
      2'b00:   be_base = 8'h01;
      2'b01:   be_base = 8'h03;
      2'b10:   be_base = 8'h0F;
      default: be_base = 8'hFF;
    endcase
    byte_en = be_base << off_q;
    for (int i = 0; i < 8; i++) begin
      bit_mask[i*8 +: 8] = {8{byte_en[i]}};
    end
    wdata_sh = wdata_q << {off_q, 3'b000};
    merged   = (data_q & ~bit_mask) | (wdata_sh & bit_mask);
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (req_mis)                 state_d = RESP;
          else if (!req_write)         state_d = READ;
          else if (req_size == 2'b11)  state_d = WRITE;   // full word: no read-back needed
          else                         state_d = READ;
        end
      end
      READ:    state_d = write_q ? WRITE : RESP;
      WRITE:   state_d = RESP;
      default: state_d = IDLE;
    endcase
  end

  // Request latch and data path register
  always_ff @(posedge clk) begin
    if (reset) begin
      write_q <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      index_q <= '0;
      off_q   <= 3'b000;
      wdata_q <= 64'h0;
      mis_q   <= 1'b0;
      data_q  <= 64'h0;
    end else begin
      if (accept) begin
        write_q <= req_write;
        size_q  <= req_size;
        uns_q   <= req_unsigned;
        index_q <= req_addr[WORD_ADDR_W+2:3];
        off_q   <= align_off;
        wdata_q <= req_wdata;
        mis_q   <= req_mis;
        data_q  <= 64'h0;
      end else if (state_q == READ) begin
        data_q  <= write_q ? mem_read_data : load_ext;
      end
    end
  end

  // Outputs; everything is held at 0 while reset is high so no write can commit
  always_comb begin
    req_ready       = (state_q == IDLE) && !reset;
    resp_valid      = 1'b0;
    resp_rdata      = 64'h0;
    resp_misaligned = 1'b0;
    mem_address     = '0;
    mem_write_data  = 64'h0;
    mem_read        = 1'b0;
    mem_write       = 1'b0;
    if (!reset) begin
      case (state_q)
        READ: begin
          mem_read    = 1'b1;
          mem_address = index_q;
        end
        WRITE: begin
          mem_write      = 1'b1;
          mem_address    = index_q;
          mem_write_data = merged;
        end
        RESP: begin
          resp_valid      = 1'b1;
          resp_misaligned = mis_q;
          resp_rdata      = (write_q || mis_q) ? 64'h0 : data_q;
        end
        default: ;
      endcase
    end
  end

endmodule
